// File: rtl/pw_addr_ctrl_if.sv
// Bus bundle for the pointwise-conv address controller: job configuration and
// handshake from the scheduler, and SRAM/PE-facing read, write and status outputs.
interface pw_addr_ctrl_if #(
  parameter int W_ADDR_W  = 10,
  parameter int D_RADDR_W = 13,
  parameter int D_WADDR_W = 14,
  parameter int CH_W      = 4,
  parameter int FN_W      = 6,
  parameter int WIN_W     = 14,
  parameter int B_ADDR_W  = 6
);
  logic                 start;
  logic [W_ADDR_W-1:0]  w_base;
  logic [CH_W-1:0]      ch_groups;
  logic [FN_W-1:0]      filt_groups;
  logic [WIN_W-1:0]     win_size;
  logic [D_WADDR_W-1:0] wr_base;
  logic                 stall;
  logic                 act_valid;

  logic [W_ADDR_W-1:0]  w_addr;
  logic                 w_rd_en;
  logic [D_RADDR_W-1:0] d_rd_addr;
  logic                 d_rd_en;
  logic                 acc_clear;
  logic                 acc_last;
  logic [D_WADDR_W-1:0] d_wr_addr;
  logic                 d_wr_en;
  logic [B_ADDR_W-1:0]  b_addr;
  logic                 b_rd_en;
  logic                 busy;
  logic                 done;
  logic                 cfg_err;

  modport master (
    output start, w_base, ch_groups, filt_groups, win_size, wr_base, stall, act_valid,
    input  w_addr, w_rd_en, d_rd_addr, d_rd_en, acc_clear, acc_last,
    input  d_wr_addr, d_wr_en, b_addr, b_rd_en, busy, done, cfg_err
  );

  modport slave (
    input  start, w_base, ch_groups, filt_groups, win_size, wr_base, stall, act_valid,
    output w_addr, w_rd_en, d_rd_addr, d_rd_en, acc_clear, acc_last,
    output d_wr_addr, d_wr_en, b_addr, b_rd_en, busy, done, cfg_err
  );
endinterface

// File: rtl/pw_addr_ctrl.sv
// Pointwise-conv read/write address sequencer (ch innermost, then pixel, then filter group).
// Define PW_BIAS_ADDR_EN to build the per-filter-group bias fetch; otherwise b_* stay 0.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; config checked and latched on start
// S_RUN   | issuing one weight/feature read per non-stalled cycle
// S_DRAIN | reads finished, waiting for all activation writes
// S_DONE  | one-cycle done pulse, then back to idle
module pw_addr_ctrl #(
  parameter int W_ADDR_W  = 10,
  parameter int D_RADDR_W = 13,
  parameter int D_WADDR_W = 14,
  parameter int CH_W      = 4,
  parameter int FN_W      = 6,
  parameter int WIN_W     = 14,
  parameter int B_ADDR_W  = 6
) (
  input logic          clk,
  input logic          rst,
  pw_addr_ctrl_if.slave bus
);
  localparam int CNT_W = WIN_W + FN_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [CH_W-1:0]      chg_q, ch_q, nxt_ch;
  logic [WIN_W-1:0]     win_q, pix_q, nxt_pix, pix_inc;
  logic [FN_W-1:0]      fng_q, filt_q, nxt_filt;
  logic [W_ADDR_W-1:0]  w_fbase_q, nxt_fbase, w_addr_q, nxt_w;
  logic [D_RADDR_W-1:0] d_rd_addr_q, nxt_d;
  logic [D_WADDR_W-1:0] wr_base_q, d_wr_addr_q;
  logic [CNT_W-1:0]     wr_cnt_q, wr_total_q;
  logic rd_en_q, rd_last_q, acc_clear_q, acc_last_q, d_wr_en_q;
  logic busy_q, done_q, cfg_err_q;
  logic cfg_bad, accept, advance, ch_last, pix_last;
  logic nxt_ch_last, nxt_grp_first, nxt_all_last;

  assign cfg_bad = (bus.ch_groups == '0) || (bus.filt_groups == '0) || (bus.win_size == '0);
  assign accept  = (state_q == S_IDLE) && bus.start && !cfg_bad;
  // rd_last_q marks that the read on the outputs is the final one of the job
  assign advance = (state_q == S_RUN) && !bus.stall && !rd_last_q;

  assign ch_last       = (ch_q == chg_q - CH_W'(1));
  assign pix_last      = (pix_q == win_q - WIN_W'(1));
  assign pix_inc       = pix_q + WIN_W'(1);
  assign nxt_ch_last   = (nxt_ch == chg_q - CH_W'(1));
  assign nxt_grp_first = (nxt_ch == '0) && (nxt_pix == '0);
  assign nxt_all_last  = nxt_ch_last && (nxt_pix == win_q - WIN_W'(1)) &&
                         (nxt_filt == fng_q - FN_W'(1));

  // Running-base address stepping: no multipliers, wraps at port width.
  always_comb begin
    nxt_ch    = ch_q + CH_W'(1);
    nxt_pix   = pix_q;
    nxt_filt  = filt_q;
    nxt_fbase = w_fbase_q;
    nxt_w     = w_addr_q + W_ADDR_W'(1);
    nxt_d     = d_rd_addr_q + D_RADDR_W'(win_q);
    if (ch_last) begin
      nxt_ch  = '0;
      nxt_pix = pix_inc;
      nxt_w   = w_fbase_q;
      nxt_d   = D_RADDR_W'(pix_inc);
      if (pix_last) begin
        nxt_pix   = '0;
        nxt_filt  = filt_q + FN_W'(1);
        nxt_fbase = w_fbase_q + W_ADDR_W'(chg_q);
        nxt_w     = w_fbase_q + W_ADDR_W'(chg_q);
        nxt_d     = '0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_RUN;
      S_RUN:   if (rd_last_q) state_d = S_DRAIN;
      S_DRAIN: if (wr_cnt_q == wr_total_q) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
      chg_q       <= '0;
      fng_q       <= '0;
      win_q       <= '0;
      wr_base_q   <= '0;
      ch_q        <= '0;
      pix_q       <= '0;
      filt_q      <= '0;
      w_fbase_q   <= '0;
      w_addr_q    <= '0;
      d_rd_addr_q <= '0;
      rd_en_q     <= 1'b0;
      rd_last_q   <= 1'b0;
      acc_clear_q <= 1'b0;
      acc_last_q  <= 1'b0;
      wr_total_q  <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= (state_d != S_IDLE);
      done_q      <= (state_d == S_DONE);
      cfg_err_q   <= (state_q == S_IDLE) && bus.start && cfg_bad;
      rd_en_q     <= 1'b0;
      acc_clear_q <= 1'b0;
      acc_last_q  <= 1'b0;
      if (accept) begin
        chg_q       <= bus.ch_groups;
        fng_q       <= bus.filt_groups;
        win_q       <= bus.win_size;
        wr_base_q   <= bus.wr_base;
        ch_q        <= '0;
        pix_q       <= '0;
        filt_q      <= '0;
        w_fbase_q   <= bus.w_base;
        w_addr_q    <= bus.w_base;
        d_rd_addr_q <= '0;
        rd_en_q     <= 1'b1;
        acc_clear_q <= 1'b1;
        acc_last_q  <= (bus.ch_groups == CH_W'(1));
        rd_last_q   <= (bus.ch_groups == CH_W'(1)) && (bus.win_size == WIN_W'(1)) &&
                       (bus.filt_groups == FN_W'(1));
        wr_total_q  <= CNT_W'(bus.win_size);
      end else if (advance) begin
        ch_q        <= nxt_ch;
        pix_q       <= nxt_pix;
        filt_q      <= nxt_filt;
        w_fbase_q   <= nxt_fbase;
        w_addr_q    <= nxt_w;
        d_rd_addr_q <= nxt_d;
        rd_en_q     <= 1'b1;
        acc_clear_q <= (nxt_ch == '0);
        acc_last_q  <= nxt_ch_last;
        rd_last_q   <= nxt_all_last;
        // expected write total grows by one window per filter group entered
        if (nxt_grp_first) wr_total_q <= wr_total_q + CNT_W'(win_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_cnt_q    <= '0;
      d_wr_en_q   <= 1'b0;
      d_wr_addr_q <= '0;
    end else begin
      d_wr_en_q <= 1'b0;
      if (accept) begin
        wr_cnt_q <= '0;
      end else if ((state_q != S_IDLE) && bus.act_valid) begin
        d_wr_en_q   <= 1'b1;
        d_wr_addr_q <= wr_base_q + D_WADDR_W'(wr_cnt_q);
        wr_cnt_q    <= wr_cnt_q + CNT_W'(1);
      end
    end
  end

`ifdef PW_BIAS_ADDR_EN
  logic [B_ADDR_W-1:0] b_addr_q;
  logic                b_rd_en_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      b_addr_q  <= '0;
      b_rd_en_q <= 1'b0;
    end else begin
      b_rd_en_q <= 1'b0;
      if (accept) begin
        b_rd_en_q <= 1'b1;
        b_addr_q  <= '0;
      end else if (advance && nxt_grp_first) begin
        b_rd_en_q <= 1'b1;
        b_addr_q  <= B_ADDR_W'(nxt_filt);
      end
    end
  end

  assign bus.b_addr  = b_addr_q;
  assign bus.b_rd_en = b_rd_en_q;
`else
  assign bus.b_addr  = '0;
  assign bus.b_rd_en = 1'b0;
`endif

  assign bus.w_addr    = w_addr_q;
  assign bus.w_rd_en   = rd_en_q;
  assign bus.d_rd_addr = d_rd_addr_q;
  assign bus.d_rd_en   = rd_en_q;
  assign bus.acc_clear = acc_clear_q;
  assign bus.acc_last  = acc_last_q;
  assign bus.d_wr_addr = d_wr_addr_q;
  assign bus.d_wr_en   = d_wr_en_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.cfg_err   = cfg_err_q;
endmodule

// File: tb/tb_pw_addr_ctrl.sv
// Self-checking bench for pw_addr_ctrl: nested-loop reference model of the read
// sequence plus a write-address queue, compared every cycle at the falling edge.
module tb_pw_addr_ctrl;
`ifdef PW_BIAS_ADDR_EN
  localparam bit BIAS = 1'b1;
`else
  localparam bit BIAS = 1'b0;
`endif

  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_errors;

  pw_addr_ctrl_if bus ();
  pw_addr_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    int w;
    int d;
    int clr;
    int lst;
    int ben;
    int b;
  } rd_t;

  rd_t exp_rd[$];
  int  exp_wr[$];
  int  obs_w[$];
  int  obs_d[$];
  int  obs_wr[$];
  rd_t mon_e;

  int n_reads, first_rd_cyc, last_rd_cyc, last_exp_w, last_exp_d;
  int n_wr, first_wr_cyc, last_wr_cyc;
  int done_cnt, done_cyc, cfg_cnt, cfg_cyc, busy_cnt, b_cnt;
  int start_cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_stats();
    n_reads = 0; first_rd_cyc = -1; last_rd_cyc = -1;
    n_wr = 0; first_wr_cyc = -1; last_wr_cyc = -1;
    done_cnt = 0; done_cyc = -1; cfg_cnt = 0; cfg_cyc = -1;
    busy_cnt = 0; b_cnt = 0;
    obs_w.delete(); obs_d.delete(); obs_wr.delete();
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("reset_outs", {bus.w_addr, bus.w_rd_en, bus.d_rd_addr, bus.d_rd_en, bus.acc_clear,
                         bus.acc_last, bus.d_wr_addr, bus.d_wr_en, bus.b_addr, bus.b_rd_en,
                         bus.busy, bus.done, bus.cfg_err}, 64'd0);
    end else begin
      if (bus.d_rd_en) begin
        chk("w_rd_en", bus.w_rd_en, 1);
        if (exp_rd.size() == 0) begin
          chk("extra_read", 1, 0);
        end else begin
          mon_e = exp_rd.pop_front();
          chk("w_addr", bus.w_addr, mon_e.w);
          chk("d_rd_addr", bus.d_rd_addr, mon_e.d);
          chk("acc_clear", bus.acc_clear, mon_e.clr);
          chk("acc_last", bus.acc_last, mon_e.lst);
          chk("b_rd_en", bus.b_rd_en, BIAS ? mon_e.ben : 0);
          if (BIAS && mon_e.ben != 0) chk("b_addr", bus.b_addr, mon_e.b);
          last_exp_w = mon_e.w;
          last_exp_d = mon_e.d;
        end
        if (n_reads == 0) first_rd_cyc = cyc;
        last_rd_cyc = cyc;
        n_reads++;
        obs_w.push_back(int'(bus.w_addr));
        obs_d.push_back(int'(bus.d_rd_addr));
      end else begin
        chk("w_rd_en", bus.w_rd_en, 0);
        if (n_reads > 0 && exp_rd.size() > 0) begin
          chk("hold_w_addr", bus.w_addr, last_exp_w);
          chk("hold_d_addr", bus.d_rd_addr, last_exp_d);
        end
      end
      if (bus.d_wr_en) begin
        if (exp_wr.size() == 0) chk("extra_write", 1, 0);
        else chk("d_wr_addr", bus.d_wr_addr, exp_wr.pop_front());
        if (n_wr == 0) first_wr_cyc = cyc;
        last_wr_cyc = cyc;
        n_wr++;
        obs_wr.push_back(int'(bus.d_wr_addr));
      end
      if (bus.done) begin done_cnt++; done_cyc = cyc; end
      if (bus.cfg_err) begin cfg_cnt++; cfg_cyc = cyc; end
      if (bus.busy) busy_cnt++;
      if (bus.b_rd_en) b_cnt++;
    end
  end

  task automatic build_model(input int wb, input int chg, input int fng, input int win,
                             input int wrb);
    rd_t e;
    exp_rd.delete();
    exp_wr.delete();
    for (int f = 0; f < fng; f++)
      for (int p = 0; p < win; p++)
        for (int c = 0; c < chg; c++) begin
          e.w   = (wb + f * chg + c) % 1024;
          e.d   = (c * win + p) % 8192;
          e.clr = (c == 0) ? 1 : 0;
          e.lst = (c == chg - 1) ? 1 : 0;
          e.ben = (c == 0 && p == 0) ? 1 : 0;
          e.b   = f % 64;
          exp_rd.push_back(e);
        end
    for (int i = 0; i < fng * win; i++) exp_wr.push_back((wrb + i) % 16384);
  endtask

  task automatic launch(input int wb, input int chg, input int fng, input int win, input int wrb);
    bus.w_base      = 10'(wb);
    bus.ch_groups   = 4'(chg);
    bus.filt_groups = 6'(fng);
    bus.win_size    = 14'(win);
    bus.wr_base     = 14'(wrb);
    bus.start       = 1'b1;
    tick();
    bus.start       = 1'b0;
    start_cyc       = cyc;
    // later config changes must not reach the running job
    bus.w_base      = ~bus.w_base;
    bus.ch_groups   = bus.ch_groups + 4'd1;
    bus.filt_groups = bus.filt_groups + 6'd2;
    bus.win_size    = bus.win_size + 14'd3;
    bus.wr_base     = ~bus.wr_base;
  endtask

  task automatic run_job(input int wb, input int chg, input int fng, input int win,
                         input int wrb, input int st_at, input int st_len, input int restart_at);
    int n;
    int nw;
    int budget;
    n  = chg * fng * win;
    nw = fng * win;
    budget = n + st_len + nw + 50;
    build_model(wb, chg, fng, win, wrb);
    clr_stats();
    launch(wb, chg, fng, win, wrb);
    for (int k = 0; k < budget && done_cnt == 0; k++) begin
      bus.stall     = (k >= st_at && k < st_at + st_len);
      bus.act_valid = (k >= 2 && k < 2 + nw);
      bus.start     = (k == restart_at);
      tick();
    end
    bus.stall = 1'b0; bus.act_valid = 1'b0; bus.start = 1'b0;
    chk("done_seen", (done_cnt > 0), 1);
    tick(); tick(); tick();
    chk("n_reads", n_reads, n);
    chk("first_read_latency", first_rd_cyc, start_cyc);
    chk("read_phase_len", last_rd_cyc - first_rd_cyc + 1, n + st_len);
    chk("n_writes", n_wr, nw);
    chk("first_write_latency", first_wr_cyc, start_cyc + 3);
    chk("done_after_write", (done_cyc > last_wr_cyc), 1);
    chk("done_pulses", done_cnt, 1);
    chk("busy_cycles", busy_cnt, done_cyc - start_cyc + 1);
    chk("busy_end", bus.busy, 0);
    chk("cfg_err_count", cfg_cnt, 0);
    chk("bias_pulses", b_cnt, BIAS ? fng : 0);
  endtask

  task automatic bad_cfg(input int chg, input int fng, input int win);
    exp_rd.delete();
    exp_wr.delete();
    clr_stats();
    launch(5, chg, fng, win, 0);
    for (int k = 0; k < 5; k++) tick();
    chk("cfg_err_pulses", cfg_cnt, 1);
    chk("cfg_err_cycle", cfg_cyc, start_cyc);
    chk("cfg_busy", busy_cnt, 0);
    chk("cfg_reads", n_reads, 0);
  endtask

  task automatic abort_job();
    build_model(200, 3, 2, 4, 30);
    clr_stats();
    launch(200, 3, 2, 4, 30);
    for (int k = 0; k < 7; k++) begin
      bus.act_valid = (k >= 2);
      tick();
    end
    bus.act_valid = 1'b0;
    #2;
    rst = 1'b0;
    exp_rd.delete();
    exp_wr.delete();
    tick(); tick(); tick();
    rst = 1'b1;
    tick(); tick();
    chk("abort_reads_seen", (n_reads > 0), 1);
    chk("abort_no_done", done_cnt, 0);
  endtask

  initial begin
    n_checks = 0; n_errors = 0; cyc = 0;
    bus.start = 1'b0; bus.w_base = '0; bus.ch_groups = '0; bus.filt_groups = '0;
    bus.win_size = '0; bus.wr_base = '0; bus.stall = 1'b0; bus.act_valid = 1'b0;
    clr_stats();
    rst = 1'b1;
    #2 rst = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();

    // base job, no stall
    run_job(100, 3, 2, 4, 500, -1, 0, -1);
    chk("lit_w0", obs_w[0], 100);
    chk("lit_w2", obs_w[2], 102);
    chk("lit_w3", obs_w[3], 100);
    chk("lit_w12", obs_w[12], 103);
    chk("lit_w23", obs_w[23], 105);
    chk("lit_d1", obs_d[1], 4);
    chk("lit_d2", obs_d[2], 8);
    chk("lit_d3", obs_d[3], 1);
    chk("lit_d23", obs_d[23], 11);
    chk("lit_wr0", obs_wr[0], 500);

    // same job, 5 stall cycles mid-run and an ignored start while busy
    run_job(100, 3, 2, 4, 500, 10, 5, 5);
    chk("lit_stall_w23", obs_w[23], 105);
    chk("lit_stall_d5", obs_d[5], 9);

    // minimal job
    run_job(7, 1, 1, 1, 50, -1, 0, -1);
    chk("lit_min_w", obs_w[0], 7);
    chk("lit_min_d", obs_d[0], 0);
    chk("lit_min_wr", obs_wr[0], 50);

    // configuration errors
    bad_cfg(3, 2, 0);
    bad_cfg(0, 2, 4);
    bad_cfg(3, 0, 4);

    // single channel group, with one stall cycle
    run_job(40, 1, 2, 3, 16383, 2, 1, -1);
    chk("lit_wrap_wr1", obs_wr[1], 0);

    // weight address wraps past 1023, three filter groups
    run_job(1020, 2, 3, 2, 9, -1, 0, -1);
    chk("lit_wwrap_8", obs_w[8], 0);
    chk("lit_wwrap_11", obs_w[11], 1);

    // feature read address wraps past 8191
    run_job(0, 3, 1, 3000, 0, -1, 0, -1);
    chk("lit_dwrap_last", obs_d[8999], 807);

    // reset mid-run, then a fresh job
    abort_job();
    run_job(100, 3, 2, 4, 500, -1, 0, -1);
    chk("lit_after_rst_w0", obs_w[0], 100);
    chk("lit_after_rst_d0", obs_d[0], 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
